// File: rtl/glb_stream_pkg.sv
// Shared constants and FSM encodings for the GLB stream reader.
package glb_stream_pkg;

    localparam int unsigned REPEAT_WIDTH = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_DELAY  = 3'd2;
    localparam logic [2:0] ST_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/glb_stream_if.sv
// Valid/ready stream toward the array input port; data MSB is the last flag.
interface glb_stream_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH:0] data;
    logic                valid;
    logic                ready;
    logic                done;

    modport master (output data, output valid, output done, input ready);
    modport slave  (input data, input valid, input done, output ready);
endinterface

// File: rtl/glb_stream_mem.sv
// 1W/1R buffer RAM with registered read port; a same-address write returns old data.
module glb_stream_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/glb_stream_reader.sv
// Preloadable buffer that streams a base/length window, optionally repeated,
// over valid/ready after a flush pulse; abortable by a new flush.
module glb_stream_reader
    import glb_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    parameter int unsigned START_DELAY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_en,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [ADDR_WIDTH:0]     cfg_tx_size,
    input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
    input  logic                    flush,
    glb_stream_if.master            strm
);

    localparam int unsigned IDX_W    = ADDR_WIDTH + 1;
    localparam int unsigned SUM_W    = ADDR_WIDTH + 2;
    localparam int unsigned WORD_W   = DATA_WIDTH + 1;
    localparam int unsigned DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam int unsigned DLY_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

    state_t state_q, state_d;
    logic   flush_q;

    logic [ADDR_WIDTH-1:0]   base_q;
    logic [IDX_W-1:0]        size_q;
    logic [REPEAT_WIDTH-1:0] rep_q;
    logic [DLY_W-1:0]        dly_q;
    logic [IDX_W-1:0]        idx_q;
    logic [REPEAT_WIDTH-1:0] pass_q;
    logic                    issued_all_q;

    logic                  rd_pend_q;
    logic                  rd_last_q;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [WORD_W-1:0] data_q;
    logic              valid_q;
    logic [WORD_W-1:0] skid_q;
    logic              skid_vld_q;
    logic              done_q;

    logic                  flush_rise;
    logic                  pop;
    logic                  final_pop;
    logic [1:0]            occ;
    logic                  slot_free;
    logic                  issue;
    logic                  latch_cfg;
    logic                  abort;
    logic                  done_d;
    logic                  wrap_idx;
    logic                  last_issue;
    logic [SUM_W-1:0]      addr_sum;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_W-1:0]     rd_word;

    assign flush_rise = flush & ~flush_q;
    assign pop        = valid_q & strm.ready;
    assign final_pop  = pop & data_q[DATA_WIDTH];
    // Occupancy counts the read in flight, so at most two words are ever held.
    assign occ        = 2'(valid_q) + 2'(skid_vld_q) + 2'(rd_pend_q);
    assign slot_free  = (occ < 2'd2) || pop;

    assign wrap_idx   = (idx_q == size_q - IDX_W'(1));
    assign last_issue = wrap_idx && (pass_q == rep_q - REPEAT_WIDTH'(1));
    assign addr_sum   = SUM_W'(base_q) + SUM_W'(idx_q);
    assign rd_addr    = (addr_sum >= SUM_W'(DEPTH)) ? ADDR_WIDTH'(addr_sum - SUM_W'(DEPTH))
                                                    : ADDR_WIDTH'(addr_sum);
    assign rd_word    = {rd_last_q, rd_data};

    glb_stream_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush;
        end
    end

    // Next state and control strobes
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        latch_cfg = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!flush) begin
                    state_d   = ST_DELAY;
                    latch_cfg = 1'b1;
                end
            end
            ST_DELAY: begin
                if (flush_rise) begin
                    state_d = ST_ARMED;
                    abort   = 1'b1;
                end else if (dly_q == DLY_W'(DLY_LAST)) begin
                    state_d = (size_q == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (flush_rise) begin
                    state_d = ST_ARMED;
                    abort   = 1'b1;
                end else begin
                    issue = !issued_all_q && slot_free;
                    if (final_pop) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush_rise) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    // Counters, read pipeline and two-entry output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            size_q       <= '0;
            rep_q        <= '0;
            dly_q        <= '0;
            idx_q        <= '0;
            pass_q       <= '0;
            issued_all_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_last_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            skid_q       <= '0;
            skid_vld_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done_d;

            if (latch_cfg) begin
                base_q       <= cfg_base;
                size_q       <= cfg_tx_size;
                rep_q        <= (cfg_repeat == '0) ? REPEAT_WIDTH'(1) : cfg_repeat;
                dly_q        <= '0;
                idx_q        <= '0;
                pass_q       <= '0;
                issued_all_q <= 1'b0;
            end

            if (state_q == ST_DELAY) dly_q <= dly_q + DLY_W'(1);

            if (issue) begin
                if (wrap_idx) begin
                    idx_q  <= '0;
                    pass_q <= pass_q + REPEAT_WIDTH'(1);
                end else begin
                    idx_q  <= idx_q + IDX_W'(1);
                end
                if (last_issue) issued_all_q <= 1'b1;
                rd_last_q <= last_issue;
            end
            rd_pend_q <= issue;

            if (abort) begin
                valid_q    <= 1'b0;
                skid_vld_q <= 1'b0;
                rd_pend_q  <= 1'b0;
            end else if (!valid_q || pop) begin
                // Head is free: refill from skid first to keep word order.
                if (skid_vld_q) begin
                    data_q     <= skid_q;
                    valid_q    <= 1'b1;
                    skid_vld_q <= rd_pend_q;
                    if (rd_pend_q) skid_q <= rd_word;
                end else if (rd_pend_q) begin
                    data_q  <= rd_word;
                    valid_q <= 1'b1;
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_q     <= rd_word;
                skid_vld_q <= 1'b1;
            end
        end
    end

    assign strm.data  = data_q;
    assign strm.valid = valid_q;
    assign strm.done  = done_q;

endmodule

// File: tb/tb_glb_stream_reader.sv
// Directed bench for glb_stream_reader: timing, wrap, repeat, backpressure, abort and reset.
module tb_glb_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [10:0] ld_addr;
    logic [15:0] ld_data;
    logic [10:0] cfg_base;
    logic [11:0] cfg_tx_size;
    logic [7:0]  cfg_repeat;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    glb_stream_if #(.DATA_WIDTH(16)) sif ();

    glb_stream_reader #(
        .DATA_WIDTH  (16),
        .DEPTH       (2048),
        .START_DELAY (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .cfg_base    (cfg_base),
        .cfg_tx_size (cfg_tx_size),
        .cfg_repeat  (cfg_repeat),
        .flush       (flush),
        .strm        (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Returns half a cycle after edge F (the edge ARMED samples flush low).
    task automatic do_flush(input int base, input int size, input int rep);
        cfg_base    = 11'(base);
        cfg_tx_size = 12'(size);
        cfg_repeat  = 8'(rep);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    // Consume a full stream; buffer holds mem[i]=i so payload is (base+i) mod 2048.
    task automatic stream_run(input string tag, input int base, input int size, input int rep,
                              input bit toggle, input bit chk_start);
        int          total = size * ((rep == 0) ? 1 : rep);
        int          k = 0;
        int          c = 0;
        bit          seen = 1'b0;
        bit          hold = 1'b0;
        logic [16:0] held = '0;
        while (k < total && c < 400) begin
            if (sif.valid && !seen) begin
                seen = 1'b1;
                if (chk_start) chk({tag, "_first_valid_cycle"}, 32'(c), 32'd5);
            end
            if (hold) begin
                chk({tag, "_stall_valid"}, 32'(sif.valid), 32'd1);
                chk({tag, "_stall_data"}, 32'(sif.data), 32'(held));
            end
            if (seen && !toggle) chk({tag, "_no_bubble"}, 32'(sif.valid), 32'd1);
            sif.ready = toggle ? (c % 2 == 0) : 1'b1;
            if (sif.valid && sif.ready) begin
                chk({tag, "_payload"}, 32'(sif.data[15:0]), 32'((base + (k % size)) % 2048));
                chk({tag, "_last"}, 32'(sif.data[16]), (k == total - 1) ? 32'd1 : 32'd0);
                k++;
                hold = 1'b0;
            end else begin
                hold = sif.valid;
                held = sif.data;
            end
            tick();
            c++;
        end
        chk({tag, "_word_count"}, 32'(k), 32'(total));
        chk({tag, "_done_before"}, 32'(sif.done), 32'd0);
        chk({tag, "_valid_after"}, 32'(sif.valid), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(sif.done), 32'd1);
        chk({tag, "_valid_done"}, 32'(sif.valid), 32'd0);
        sif.ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        cfg_base = '0; cfg_tx_size = '0; cfg_repeat = '0; flush = 1'b0;
        sif.ready = 1'b1;
        tick(); tick();
        chk("reset_data", 32'(sif.data), 32'd0);
        chk("reset_valid", 32'(sif.valid), 32'd0);
        chk("reset_done", 32'(sif.done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 2048; i++) begin
            ld_en = 1'b1; ld_addr = 11'(i); ld_data = 16'(i);
            tick();
        end
        ld_en = 1'b0;
        chk("idle_valid", 32'(sif.valid), 32'd0);

        // Basic 32-word pass with ready held high
        do_flush(0, 32, 1);
        stream_run("basic", 0, 32, 1, 1'b0, 1'b1);

        // Window wrapping past the top of the buffer
        do_flush(2046, 4, 1);
        stream_run("wrap", 2046, 4, 1, 1'b0, 1'b1);

        // Two passes under alternating backpressure
        do_flush(0, 3, 2);
        stream_run("repeat_bp", 0, 3, 2, 1'b1, 1'b1);

        // Zero-length window: done without any valid
        do_flush(0, 0, 1);
        for (int c = 0; c < 8; c++) begin
            chk("size0_valid", 32'(sif.valid), 32'd0);
            chk("size0_done", 32'(sif.done), (c >= 4) ? 32'd1 : 32'd0);
            tick();
        end

        // Repeat count 0 behaves as one pass
        do_flush(10, 2, 0);
        stream_run("repeat0", 10, 2, 0, 1'b0, 1'b1);

        // Abort after five transfers, then a fresh run
        do_flush(0, 32, 1);
        repeat (5) tick();
        for (int j = 0; j < 5; j++) begin
            chk("abort_pre_payload", 32'(sif.data[15:0]), 32'(j));
            tick();
        end
        chk("abort_pre_valid", 32'(sif.valid), 32'd1);
        flush = 1'b1; sif.ready = 1'b0;
        tick();
        chk("abort_valid", 32'(sif.valid), 32'd0);
        chk("abort_done", 32'(sif.done), 32'd0);
        cfg_base = 11'd0; cfg_tx_size = 12'd8; cfg_repeat = 8'd1;
        flush = 1'b0; sif.ready = 1'b1;
        tick();
        chk("abort_armed_done", 32'(sif.done), 32'd0);
        stream_run("abort_rerun", 0, 8, 1, 1'b0, 1'b1);

        // Reset mid-stream while stalled
        do_flush(100, 20, 1);
        repeat (5) tick();
        sif.ready = 1'b0;
        repeat (3) tick();
        chk("rst_pre_valid", 32'(sif.valid), 32'd1);
        chk("rst_pre_data", 32'(sif.data[15:0]), 32'd100);
        rst = 1'b1;
        tick();
        chk("rst_data", 32'(sif.data), 32'd0);
        chk("rst_valid", 32'(sif.valid), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        rst = 1'b0; sif.ready = 1'b1;
        tick();
        do_flush(100, 20, 1);
        stream_run("post_rst", 100, 20, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/glb_stream_reader.md
# glb_stream_reader

Synthesizable, parametrised successor to the GLB write-stream source: a preloadable local buffer that, after a flush pulse, streams a configurable window of words to a CGRA IO tile over a valid/ready handshake. It adds a programmable base address and length, multi-pass repeat, an end-of-stream marker bit and full backpressure support. It sits between the GLB model/host load path and the array input port in memory-core and sparse tests, and is intended to be usable in RTL, not only in benches.

## Interface
- DATA_WIDTH, 16, payload bits per word
- DEPTH, 2048, buffer words
- ADDR_WIDTH, $clog2(DEPTH), buffer address width
- START_DELAY, 3, idle cycles between flush release and first read
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ld_en  in  1  preload write strobe
- ld_addr  in  ADDR_WIDTH  preload address
- ld_data  in  DATA_WIDTH  preload data
- cfg_base  in  ADDR_WIDTH  first word address
- cfg_tx_size  in  ADDR_WIDTH+1  words per pass (0..DEPTH)
- cfg_repeat  in  8  pass count; 0 treated as 1
- flush  in  1  start trigger (high then low)
- data  out  DATA_WIDTH+1  bit DATA_WIDTH = last flag; low bits = payload
- valid  out  1  data valid
- ready  in  1  consumer ready
- done  out  1  stream complete

## Operation
- States: IDLE, ARMED, DELAY, STREAM, DONE.
- IDLE: wait for flush sampled 1 -> ARMED. ARMED: wait for flush sampled 0 -> DELAY; call that edge F. cfg_* latched at F.
- DELAY: count START_DELAY cycles -> STREAM. If latched tx_size == 0 -> DONE instead (no valid ever).
- STREAM: issue reads at base+idx (mod DEPTH, wrap-around), idx 0..tx_size-1, repeated for max(repeat,1) passes. Reads issue only when a slot is free in the 2-entry output buffer (counting in-flight read).
- Handshake: transfer when valid && ready. data/valid stable while valid && !ready. No bubbles while ready held high.
- last flag = 1 only on final word of final pass; 0 otherwise.
- After final transfer -> DONE; done held high, valid low, until flush rises (-> ARMED, done cleared) or rst.
- flush rising in DELAY/STREAM: abort; buffer and in-flight read discarded, valid low next cycle, -> ARMED, done stays 0.
- ld_en accepted in every state; same-address read and write in one cycle returns old data.
- Counters: idx ADDR_WIDTH+1 bits, pass 8 bits; no overflow for legal configs.

## Timing
- Reset values: data 0, valid 0, done 0; state IDLE; buffer empty.
- Memory read latency 1 cycle (registered RAM output).
- First valid rises at edge F+START_DELAY+2.
- Steady state with ready=1: one word per cycle, including pass boundaries.
- ready deasserted: at most 2 words buffered; reads stall; resume with no loss or duplication.
- done rises the edge after the final transfer edge.
- rst mid-stream: all outputs return to reset values the following edge; buffer contents preserved.

## Structure
- glb_stream_pkg: state enum, REPEAT_WIDTH=8 constant.
- Sub-module glb_stream_mem: 1W/1R synchronous-read RAM, DEPTH x DATA_WIDTH.
- Top holds FSM, address/pass counters, 2-entry output buffer.

## Test plan
- Preload mem[i]=i, base 0, size 32, repeat 1, ready=1 -> 32 words 0..31 on consecutive cycles from F+5; last only on word 31; done at next edge.
- Base 2046, size 4 -> payloads 2046, 2047, 0, 1 (wrap).
- Size 3, repeat 2, ready toggled 1,0,1,0... -> sequence 0,1,2,0,1,2 exactly once each, data stable while stalled, last only on 6th.
- Size 0 -> valid never rises; done at F+START_DELAY+1.
- Flush pulse mid-stream after 5 transfers -> valid low next cycle, new flush run restarts from base word 0, done only after full new stream.
- rst asserted mid-stream with ready=0 -> data 0, valid 0, done 0 next edge; subsequent flush streams preloaded data unchanged.
